bus_xfer_seq: RTL and testbench
===============================

BUS_XFER_SEQ -- requirements
Module: bus_xfer_seq

Interface
REQ-001 SHALL have parameter NSRC, default 8: number of bus source registers, oe lines per bus.
REQ-002 SHALL have parameter NDST, default 8: number of destination registers, latch/clear lines.
REQ-003 SHALL have parameter SETTLE, default 1, range 1..15: cycles oe is held before latch rises.
REQ-004 SHALL have port CLK, input, 1: sole clock, rising-edge.
REQ-005 SHALL have port RESET_N, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, 1: transfer request present.
REQ-007 SHALL have port req_ready, output, 1: sequencer idle; request accepted when valid&ready.
REQ-008 SHALL have port req_bus, input, 1: 0 selects bus 1 (oe1), 1 selects bus 2 (oe2).
REQ-009 SHALL have port req_src, input, $clog2(NSRC): source index to enable onto the bus.
REQ-010 SHALL have port req_dst, input, NDST: destination bitmask, multiple bits allowed.
REQ-011 SHALL have port req_clr, input, 1: clear destinations instead of transferring.
REQ-012 SHALL have port oe1 and port oe2, output, NSRC each: one-hot-or-zero source enables.
REQ-013 SHALL have port latch, output, NDST: destination latch strobes.
REQ-014 SHALL have port clear, output, NDST: destination clear strobes.
REQ-015 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-016 SHALL have port err, output, 1: one-cycle pulse with done on a rejected request.

Function
REQ-017 SHALL capture req_bus/src/dst/clr on acceptance; inputs are ignored afterwards until next acceptance.
REQ-018 SHALL implement states IDLE, DRIVE, STROBE, HOLD, CLR; req_ready=1 only in IDLE.
REQ-019 Transfer: IDLE->DRIVE for exactly SETTLE cycles->STROBE 1 cycle->HOLD 1 cycle->IDLE.
REQ-020 Selected oe bit SHALL be high throughout DRIVE, STROBE and HOLD, low in IDLE and CLR.
REQ-021 latch SHALL equal the captured dst mask during STROBE only, zero otherwise.
REQ-022 done SHALL be high during HOLD; first transfer accepted at edge k gives done in cycle k+SETTLE+2.
REQ-023 Clear (req_clr=1): IDLE->CLR 1 cycle->IDLE; clear=dst mask and done=1 during CLR; no oe asserted.
REQ-024 Out-of-range req_src (>=NSRC) or dst==0 on a transfer SHALL go IDLE->CLR-timed single cycle with done=1, err=1, no oe/latch/clear.
REQ-025 At most one bit of oe1|oe2 combined SHALL be high in any cycle.
REQ-026 Back-to-back: a request valid in the cycle after done SHALL be accepted then (ready high in IDLE).
REQ-027 req_clr=1 with dst==0 SHALL complete as a no-op with done=1, err=0.

Reset
REQ-028 RESET_N low SHALL asynchronously force IDLE, oe1=oe2=0, latch=0, clear=0, done=0, err=0, SETTLE counter 0.
REQ-029 Reset mid-transfer SHALL drop all strobes immediately; no done for the aborted request.
REQ-030 req_ready SHALL be 0 while RESET_N low and 1 in the first cycle after release.

Structure
REQ-031 State encoding enum and default NSRC/NDST constants SHALL live in shared package pdp8_bus_pkg.
REQ-032 SETTLE countdown SHALL be a sub-module settle_timer (load, count, expire); rest is one FSM.
REQ-033 All outputs SHALL be registered; no combinational path from req_* to oe/latch/clear.

Verification
REQ-034 SETTLE=1, bus 0, src 3, dst 8'h05 accepted at cycle 0 -> oe1=8'h08 cycles 1-3, latch=8'h05 cycle 2, done cycle 3.
REQ-035 SETTLE=3, bus 1, src 7, dst 8'h80 -> oe2=8'h80 cycles 1-5, latch=8'h80 cycle 4 only, done cycle 5, oe1 stays 0.
REQ-036 req_clr=1, dst 8'hFF -> clear=8'hFF cycle 1, done cycle 1, oe/latch all 0, ready cycle 2.
REQ-037 src 2, dst 8'h00 -> done=err=1 in cycle 1, no oe/latch/clear activity.
REQ-038 RESET_N pulsed low in STROBE cycle -> latch, oe, done zero asynchronously; ready=1 after release; no done pulse.
REQ-039 Two requests held valid continuously -> second accepted cycle after first done; random run asserts REQ-025 every cycle.

Source files
------------

// File: rtl/pdp8_bus_pkg.sv
// pdp8_bus_pkg: shared sequencer state encoding and default bus geometry
package pdp8_bus_pkg;
  localparam int NSRC_DEF = 8;
  localparam int NDST_DEF = 8;
  typedef enum logic [2:0] {IDLE, DRIVE, STROBE, HOLD, CLR} state_t;
endpackage

// File: rtl/settle_timer.sv
// settle_timer: counts the cycles a source stays on the bus before its destinations are latched
module settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic i_load,
  input  logic i_count,
  output logic o_expire
);
  logic [3:0] r_cnt;
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_cnt <= '0;
    else if (i_load) r_cnt <= 4'(SETTLE);
    else if (i_count && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
  end
  assign o_expire = i_count && r_cnt == 4'd1;
endmodule

// File: rtl/bus_xfer_seq.sv
// bus_xfer_seq: runs one source-to-destinations bus transfer or a destination clear per request
module bus_xfer_seq
  import pdp8_bus_pkg::*;
#(
  parameter int NSRC = NSRC_DEF,
  parameter int NDST = NDST_DEF,
  parameter int SETTLE = 1,
  localparam int SW = NSRC > 1 ? $clog2(NSRC) : 1
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_bus,
  input  logic [SW-1:0]   req_src,
  input  logic [NDST-1:0] req_dst,
  input  logic            req_clr,
  output logic [NSRC-1:0] oe1,
  output logic [NSRC-1:0] oe2,
  output logic [NDST-1:0] latch,
  output logic [NDST-1:0] clear,
  output logic            done,
  output logic            err
);
  state_t r_state, w_next;
  logic r_bus;
  logic [SW-1:0] r_src, w_src;
  logic [NDST-1:0] r_dst, w_latch, w_clear;
  logic w_accept, w_bad, w_expire, w_bus, w_oe_on, w_done, w_err;
  assign w_accept = req_valid && req_ready;
  assign w_bad = !req_clr && (32'(req_src) >= NSRC || req_dst == '0);
  assign w_bus = w_accept ? req_bus : r_bus;
  assign w_src = w_accept ? req_src : r_src;
  settle_timer #(.SETTLE(SETTLE)) u_timer (
    .CLK,
    .RESET_N,
    .i_load(w_accept && !req_clr && !w_bad),
    .i_count(r_state == DRIVE),
    .o_expire(w_expire)
  );
  // CLR is only ever entered straight from IDLE, so req_* still describe the request there
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && (req_clr || w_bad)) w_next = CLR;
        else if (w_accept) w_next = DRIVE;
      end
      DRIVE: if (w_expire) w_next = STROBE;
      STROBE: w_next = HOLD;
      default: w_next = IDLE;
    endcase
    w_oe_on = w_next == DRIVE || w_next == STROBE || w_next == HOLD;
    w_latch = w_next == STROBE ? r_dst : '0;
    w_clear = (w_next == CLR && req_clr) ? req_dst : '0;
    w_err = w_next == CLR && w_bad;
    w_done = w_next == HOLD || w_next == CLR;
  end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= IDLE;
      req_ready <= 1'b0;
      oe1 <= '0;
      oe2 <= '0;
      latch <= '0;
      clear <= '0;
      done <= 1'b0;
      err <= 1'b0;
      r_bus <= 1'b0;
      r_src <= '0;
      r_dst <= '0;
    end else begin
      r_state <= w_next;
      req_ready <= w_next == IDLE;
      oe1 <= (w_oe_on && !w_bus) ? NSRC'(1) << w_src : '0;
      oe2 <= (w_oe_on && w_bus) ? NSRC'(1) << w_src : '0;
      latch <= w_latch;
      clear <= w_clear;
      done <= w_done;
      err <= w_err;
      if (w_accept) begin
        r_bus <= req_bus;
        r_src <= req_src;
        r_dst <= req_dst;
      end
    end
  end
endmodule

// File: tb/tb_bus_xfer_seq.sv
// tb_bus_xfer_seq: scoreboard bench driving a SETTLE=1 and a SETTLE=3 sequencer from shared stimulus
module tb_bus_xfer_seq;
  typedef struct packed {
    logic       err;
    logic [7:0] latch;
    logic [7:0] clear;
    logic [7:0] oe1;
    logic [7:0] oe2;
  } exp_t;
  typedef struct {
    logic       bus;
    logic [2:0] src;
    logic [7:0] dst;
    logic       clr;
    exp_t       e;
  } vec_t;
  logic CLK = 1'b0, RESET_N = 1'b1;
  logic req_valid = 1'b0, req_bus = 1'b0, req_clr = 1'b0;
  logic [2:0] req_src = 3'd0;
  logic [7:0] req_dst = 8'd0;
  logic [1:0] ready_w, done_w, err_w;
  logic [1:0][7:0] oe1_w, oe2_w, latch_w, clear_w;
  int tests = 0, fails = 0;
  exp_t q0[$], q1[$];
  int sv[2] = '{1, 3};
  bit busy[2];
  int cnt[2], lat_at[2], lat_n[2], oe_n[2];
  logic [7:0] a_l[2], a_c[2], a_o1[2], a_o2[2];
  always #5 CLK = ~CLK;
  bus_xfer_seq #(.SETTLE(1)) u1 (
    .CLK(CLK), .RESET_N(RESET_N), .req_valid(req_valid), .req_ready(ready_w[0]),
    .req_bus(req_bus), .req_src(req_src), .req_dst(req_dst), .req_clr(req_clr),
    .oe1(oe1_w[0]), .oe2(oe2_w[0]), .latch(latch_w[0]), .clear(clear_w[0]),
    .done(done_w[0]), .err(err_w[0])
  );
  bus_xfer_seq #(.SETTLE(3)) u3 (
    .CLK(CLK), .RESET_N(RESET_N), .req_valid(req_valid), .req_ready(ready_w[1]),
    .req_bus(req_bus), .req_src(req_src), .req_dst(req_dst), .req_clr(req_clr),
    .oe1(oe1_w[1]), .oe2(oe2_w[1]), .latch(latch_w[1]), .clear(clear_w[1]),
    .done(done_w[1]), .err(err_w[1])
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic exp_t model(input logic bus, input logic [2:0] src, input logic [7:0] dst, input logic clr);
    exp_t e;
    logic x;
    x = !clr && dst != 8'd0;
    e.err = !clr && dst == 8'd0;
    e.latch = x ? dst : 8'd0;
    e.clear = clr ? dst : 8'd0;
    e.oe1 = (x && !bus) ? 8'd1 << src : 8'd0;
    e.oe2 = (x && bus) ? 8'd1 << src : 8'd0;
    return e;
  endfunction
  // per-instance monitor: accumulates activity from acceptance to done, then scores it
  always @(negedge CLK) begin
    exp_t e;
    int s;
    logic x;
    for (int k = 0; k < 2; k++) begin
      if (!RESET_N) begin
        busy[k] = 1'b0;
        if (k == 0) q0.delete(); else q1.delete();
      end else begin
        chk("onehot_oe", 32'($countones({oe1_w[k], oe2_w[k]}) <= 1), 32'd1);
        chk("err_without_done", 32'(err_w[k] && !done_w[k]), 32'd0);
        if (!busy[k]) chk("done_while_idle", 32'(done_w[k]), 32'd0);
        else begin
          cnt[k]++;
          a_l[k] |= latch_w[k];
          a_c[k] |= clear_w[k];
          a_o1[k] |= oe1_w[k];
          a_o2[k] |= oe2_w[k];
          if (latch_w[k] != 8'd0) begin lat_at[k] = cnt[k]; lat_n[k]++; end
          if ((oe1_w[k] | oe2_w[k]) != 8'd0) oe_n[k]++;
          if (done_w[k]) begin
            busy[k] = 1'b0;
            chk("sb_nonempty", 32'(k == 0 ? q0.size() : q1.size()) != 0 ? 32'd1 : 32'd0, 32'd1);
            if ((k == 0 ? q0.size() : q1.size()) != 0) begin
              if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
              s = sv[k];
              x = e.latch != 8'd0;
              chk($sformatf("err[S=%0d]", s), 32'(err_w[k]), 32'(e.err));
              chk($sformatf("latch_mask[S=%0d]", s), 32'(a_l[k]), 32'(e.latch));
              chk($sformatf("clear_mask[S=%0d]", s), 32'(a_c[k]), 32'(e.clear));
              chk($sformatf("oe1_mask[S=%0d]", s), 32'(a_o1[k]), 32'(e.oe1));
              chk($sformatf("oe2_mask[S=%0d]", s), 32'(a_o2[k]), 32'(e.oe2));
              chk($sformatf("done_latency[S=%0d]", s), 32'(cnt[k]), x ? 32'(s + 2) : 32'd1);
              chk($sformatf("latch_cycle[S=%0d]", s), 32'(lat_at[k]), x ? 32'(s + 1) : 32'd0);
              chk($sformatf("latch_cycles[S=%0d]", s), 32'(lat_n[k]), x ? 32'd1 : 32'd0);
              chk($sformatf("oe_cycles[S=%0d]", s), 32'(oe_n[k]), x ? 32'(s + 2) : 32'd0);
            end
          end
        end
        if (req_valid && ready_w[k]) begin
          busy[k] = 1'b1;
          cnt[k] = 0; lat_at[k] = 0; lat_n[k] = 0; oe_n[k] = 0;
          a_l[k] = 8'd0; a_c[k] = 8'd0; a_o1[k] = 8'd0; a_o2[k] = 8'd0;
        end
      end
    end
  end
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (ready_w != 2'b11 && n < 50) begin tick(); n++; end
    chk("idle_reached", 32'(ready_w), 32'd3);
  endtask
  task automatic send(input logic bus, input logic [2:0] src, input logic [7:0] dst, input logic clr, input exp_t e);
    wait_idle();
    req_bus = bus; req_src = src; req_dst = dst; req_clr = clr; req_valid = 1'b1;
    q0.push_back(e);
    q1.push_back(e);
    tick();
    req_valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    vec_t tv[8];
    int n;
    logic rb, rc;
    logic [2:0] rs;
    logic [7:0] rd;
    tv[0] = '{1'b0, 3'd3, 8'h05, 1'b0, '{1'b0, 8'h05, 8'h00, 8'h08, 8'h00}};
    tv[1] = '{1'b1, 3'd7, 8'h80, 1'b0, '{1'b0, 8'h80, 8'h00, 8'h00, 8'h80}};
    tv[2] = '{1'b0, 3'd0, 8'hFF, 1'b1, '{1'b0, 8'h00, 8'hFF, 8'h00, 8'h00}};
    tv[3] = '{1'b0, 3'd2, 8'h00, 1'b0, '{1'b1, 8'h00, 8'h00, 8'h00, 8'h00}};
    tv[4] = '{1'b1, 3'd5, 8'h00, 1'b1, '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00}};
    tv[5] = '{1'b1, 3'd0, 8'h3C, 1'b0, '{1'b0, 8'h3C, 8'h00, 8'h00, 8'h01}};
    tv[6] = '{1'b0, 3'd5, 8'hFF, 1'b0, '{1'b0, 8'hFF, 8'h00, 8'h20, 8'h00}};
    tv[7] = '{1'b1, 3'd6, 8'h12, 1'b1, '{1'b0, 8'h00, 8'h12, 8'h00, 8'h00}};
    #3 RESET_N = 1'b0;
    #1;
    chk("rst_ready", 32'(ready_w), 32'd0);
    chk("rst_oe", 32'({oe1_w, oe2_w}), 32'd0);
    chk("rst_latch_clear", 32'({latch_w, clear_w}), 32'd0);
    chk("rst_done_err", 32'({done_w, err_w}), 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1 RESET_N = 1'b1;
    tick();
    chk("ready_after_release", 32'(ready_w), 32'd3);
    foreach (tv[i]) send(tv[i].bus, tv[i].src, tv[i].dst, tv[i].clr, tv[i].e);
    for (int i = 0; i < 30; i++) begin
      rb = 1'($urandom_range(0, 1));
      rs = 3'($urandom_range(0, 7));
      rd = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      rc = $urandom_range(0, 3) == 0;
      send(rb, rs, rd, rc, model(rb, rs, rd, rc));
    end
    // back-to-back on the SETTLE=1 instance: second request held valid while the first runs
    wait_idle();
    req_bus = 1'b0; req_src = 3'd1; req_dst = 8'h02; req_clr = 1'b0; req_valid = 1'b1;
    q0.push_back(model(1'b0, 3'd1, 8'h02, 1'b0));
    q1.push_back(model(1'b0, 3'd1, 8'h02, 1'b0));
    tick();
    req_bus = 1'b1; req_src = 3'd6; req_dst = 8'h41;
    q0.push_back(model(1'b1, 3'd6, 8'h41, 1'b0));
    n = 0;
    while (!ready_w[0] && n < 20) begin tick(); n++; end
    chk("b2b_ready_gap", 32'(n), 32'd3);
    tick();
    req_valid = 1'b0;
    chk("b2b_second_accepted", 32'(ready_w[0]), 32'd0);
    // asynchronous reset while the SETTLE=1 instance is strobing
    wait_idle();
    req_bus = 1'b0; req_src = 3'd4; req_dst = 8'h0F; req_clr = 1'b0; req_valid = 1'b1;
    q0.push_back(model(1'b0, 3'd4, 8'h0F, 1'b0));
    q1.push_back(model(1'b0, 3'd4, 8'h0F, 1'b0));
    tick();
    req_valid = 1'b0;
    n = 0;
    while (latch_w[0] == 8'd0 && n < 10) begin tick(); n++; end
    chk("strobe_reached", 32'(latch_w[0]), 32'h0F);
    chk("strobe_oe_before_abort", 32'(oe1_w[0]), 32'h10);
    #2 RESET_N = 1'b0;
    #1;
    chk("abort_latch", 32'(latch_w), 32'd0);
    chk("abort_oe", 32'({oe1_w, oe2_w}), 32'd0);
    chk("abort_done", 32'(done_w), 32'd0);
    chk("abort_ready", 32'(ready_w), 32'd0);
    @(negedge CLK);
    #1 RESET_N = 1'b1;
    tick();
    chk("ready_after_abort", 32'(ready_w), 32'd3);
    repeat (6) begin
      tick();
      chk("no_done_after_abort", 32'(done_w), 32'd0);
    end
    send(tv[0].bus, tv[0].src, tv[0].dst, tv[0].clr, tv[0].e);
    wait_idle();
    tick();
    chk("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
